// File: rtl/tqvp_sample_capture.sv
// Sample capture front end for the FIR peripheral: synchronises ui_in, samples it at a
// programmable rate into a small FIFO that firmware drains over the byte register bus.
module tqvp_sample_capture #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_DIV    = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;

  logic [7:0]       sync1, sync2;
  logic             en, en_nxt;
  logic [7:0]       div, div_nxt;
  logic [7:0]       tcnt, tcnt_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt;
  logic [7:0]       mem [DEPTH];

  logic wr_ctrl, wr_div, wr_pop, wr_clr, flush;
  logic empty, full, tick, pop_ok, push, ovf_set;

  // Next-state for control, tick counter and FIFO bookkeeping
  always_comb begin
    en_nxt     = en;
    div_nxt    = div;
    tcnt_nxt   = tcnt;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    ovf_nxt    = ovf;

    wr_ctrl = data_write && (address == ADDR_CTRL);
    wr_div  = data_write && (address == ADDR_DIV);
    wr_pop  = data_write && (address == ADDR_DATA);
    wr_clr  = data_write && (address == ADDR_STATUS) && data_in[2];
    flush   = wr_ctrl && data_in[1];

    empty = (count == '0);
    full  = (count == CNT_W'(DEPTH));

    // A register write restarts the sample period, so no tick lands in that cycle
    tick    = en && (tcnt == div) && !wr_ctrl && !wr_div;
    pop_ok  = wr_pop && !empty;
    push    = tick && (!full || pop_ok);
    ovf_set = tick && full && !pop_ok;

    if (!en || wr_ctrl || wr_div || tick) begin
      tcnt_nxt = '0;
    end else begin
      tcnt_nxt = tcnt + 8'd1;
    end

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end
      if (push && !pop_ok) begin
        count_nxt = count + CNT_W'(1);
      end else if (pop_ok && !push) begin
        count_nxt = count - CNT_W'(1);
      end
    end

    if (ovf_set) begin
      ovf_nxt = 1'b1;
    end else if (wr_clr) begin
      ovf_nxt = 1'b0;
    end

    if (wr_ctrl) begin
      en_nxt = data_in[0];
    end
    if (wr_div) begin
      div_nxt = data_in;
    end
  end

  // State registers; uo_out is taken from next-state so flags track STATUS exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      en     <= 1'b0;
      div    <= '0;
      tcnt   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      uo_out <= '0;
    end else begin
      sync1  <= ui_in;
      sync2  <= sync1;
      en     <= en_nxt;
      div    <= div_nxt;
      tcnt   <= tcnt_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      uo_out <= {6'b0, ovf_nxt, (count_nxt != '0)};
    end
  end

  // Storage carries no reset; contents are only visible through count-qualified reads
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) begin
      mem[wr_ptr] <= sync2;
    end
  end

  // Register read mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL:   data_out = {7'b0, en};
      ADDR_DIV:    data_out = div;
      ADDR_DATA:   data_out = empty ? 8'h00 : mem[rd_ptr];
      ADDR_STATUS: data_out = {4'(count), 1'b0, ovf, full, empty};
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_sample_capture.sv
// Randomised bench for tqvp_sample_capture, checked cycle by cycle against a
// queue-based model of the capture FIFO and its register map.
module tb_tqvp_sample_capture;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  tqvp_sample_capture #(.DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit live  = 1'b0;

  // Reference state
  logic [7:0] q[$];
  bit         m_en;
  int         m_div;
  int         m_since;
  bit         m_ovf;
  logic [7:0] hist[2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    int n;
    n = q.size();
    case (a)
      4'h0: return {7'b0, m_en};
      4'h1: return 8'(m_div);
      4'h2: return (n == 0) ? 8'h00 : q[0];
      4'h3: return {4'(n), 1'b0, m_ovf, (n == DEPTH), (n == 0)};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_uo();
    return {6'b0, m_ovf, (q.size() != 0)};
  endfunction

  task automatic m_step(input logic r, input logic [3:0] a, input logic w,
                        input logic [7:0] d, input logic [7:0] u);
    bit wctrl, wdiv, pop, clr, flush, tick;
    logic [7:0] samp;
    if (!r) begin
      q.delete();
      m_en = 0; m_div = 0; m_since = 0; m_ovf = 0;
      hist[0] = 8'h00; hist[1] = 8'h00;
      return;
    end
    samp  = hist[0];
    wctrl = w && (a == 4'h0);
    wdiv  = w && (a == 4'h1);
    pop   = w && (a == 4'h2);
    clr   = w && (a == 4'h3) && d[2];
    flush = wctrl && d[1];
    // One sample every div+1 enabled cycles, period restarted by any CTRL/DIV write
    tick  = m_en && (m_since == m_div) && !wctrl && !wdiv;
    if (!m_en || wctrl || wdiv || tick) m_since = 0;
    else m_since = m_since + 1;
    if (flush) begin
      q.delete();
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (tick) begin
        if (q.size() < DEPTH) q.push_back(samp);
        else m_ovf = 1;
      end
    end
    if (clr && !(tick && !flush && q.size() == DEPTH && !(pop))) begin
      // clear only when no overflow was raised this cycle
    end
    hist[0] = hist[1];
    hist[1] = u;
    if (wctrl) m_en = d[0];
    if (wdiv)  m_div = int'(d);
  endtask

  bit ovf_raised;

  task automatic cycle(input logic r, input logic [3:0] a, input logic w,
                       input logic [7:0] d, input logic [7:0] u);
    bit pre_ovf;
    rst_n = r; address = a; data_write = w; data_in = d; ui_in = u;
    #1;
    if (live) chk($sformatf("rd[%0h]", a), data_out, m_read(a));
    @(posedge clk);
    pre_ovf = m_ovf;
    m_ovf = 0;
    m_step(r, a, w, d, u);
    // Sticky overflow: set this cycle wins over a same-cycle clear
    if (r) begin
      if (m_ovf) m_ovf = 1;
      else if (w && a == 4'h3 && d[2]) m_ovf = 0;
      else m_ovf = pre_ovf;
    end
    live = 1'b1;
    #1;
    chk("uo_out", uo_out, m_uo());
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [3:0] a, input logic [7:0] u);
    for (int i = 0; i < n; i++) cycle(1'b1, a, 1'b0, 8'h00, u);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] u);
    cycle(1'b1, a, 1'b1, d, u);
  endtask

  initial begin
    rst_n = 1'b0; address = '0; data_write = 1'b0; data_in = '0; ui_in = '0;
    @(negedge clk);

    // Reset and register defaults
    cycle(1'b0, 4'h0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 4'h0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i), 1'b0, 8'h00, 8'h00);
    chk("rst_status", data_out, 8'h01);
    chk("rst_uo", uo_out, 8'h00);

    // Slow capture of a constant
    wr(4'h1, 8'd3, 8'h5A);
    wr(4'h0, 8'h01, 8'h5A);
    idle(12, 4'h3, 8'h5A);
    chk("div3_status", data_out, 8'h30);
    idle(1, 4'h2, 8'h5A);
    chk("div3_data", data_out, 8'h5A);

    // Fast ramp into overflow, then drain
    wr(4'h0, 8'h02, 8'h00);
    wr(4'h1, 8'd0, 8'h00);
    wr(4'h0, 8'h01, 8'h00);
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'h3, 1'b0, 8'h00, 8'(i));
    wr(4'h0, 8'h00, 8'h00);
    idle(1, 4'h3, 8'h00);
    chk("ramp_status", data_out, 8'h86);
    for (int i = 0; i < DEPTH; i++) wr(4'h2, 8'h00, 8'h00);
    idle(1, 4'h2, 8'h00);
    chk("drained_data", data_out, 8'h00);

    // Full FIFO with a pop on every tick, then clear overflow and flush
    wr(4'h3, 8'h04, 8'h11);
    wr(4'h0, 8'h01, 8'h22);
    idle(10, 4'h3, 8'h33);
    for (int i = 0; i < 6; i++) wr(4'h2, 8'h00, 8'(8'h40 + i));
    idle(1, 4'h3, 8'h00);
    wr(4'h3, 8'h04, 8'h00);
    wr(4'h1, 8'd7, 8'h00);
    for (int i = 0; i < 24; i++) wr(4'h2, 8'h00, 8'(i));
    idle(45, 4'h3, 8'h77);
    wr(4'h0, 8'h03, 8'h00);
    idle(1, 4'h0, 8'h00);
    chk("flush_en", data_out, 8'h01);

    // Random traffic with occasional mid-run reset
    for (int n = 0; n < 4000; n++) begin
      logic r;
      logic [3:0] a;
      logic w;
      logic [7:0] d;
      int k;
      r = ($urandom_range(0, 399) != 0);
      k = $urandom_range(0, 19);
      w = 1'b1;
      d = 8'($urandom);
      case (k)
        0: begin a = 4'h0; d = {6'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0)}; end
        1: begin a = 4'h1; d = 8'($urandom_range(0, 4)); end
        2, 3, 4, 5, 6: a = 4'h2;
        7: a = 4'h3;
        8: a = 4'($urandom_range(4, 15));
        default: begin a = 4'($urandom_range(0, 15)); w = 1'b0; end
      endcase
      cycle(r, a, w, d, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0x00 expected 0x01");
    $fatal(1, "timeout");
  end

endmodule
